// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan driver: snapshot register, leading-zero blanking,
// per-digit blink and decimal points, with registered anode/segment pins.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned SCAN_DIV   = 16,
  parameter int unsigned BLINK_DIV  = 26,
  parameter int unsigned ACTIVE_LOW = 1,
  localparam int unsigned IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  iclk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [DIGITS-1:0]     anode,
  output logic [7:0]            segment,
  output logic [IW-1:0]         digit_idx
);

  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{ACTIVE_LOW != 0}};
  localparam logic [7:0]        SEG_OFF  = {8{ACTIVE_LOW != 0}};
  localparam logic [IW-1:0]     LAST_IDX = IW'(DIGITS - 1);

  logic [SCAN_DIV-1:0]  prescaler;
  logic [BLINK_DIV-1:0] blink_cnt;
  logic [4*DIGITS-1:0]  snap_data;
  logic [DIGITS-1:0]    snap_dp;
  logic                 tick;
  logic                 blink_phase;
  logic [DIGITS-1:0]    upper_zero;
  logic [DIGITS-1:0]    anode_c;
  logic [7:0]           seg_c;
  logic [3:0]           nib;
  logic                 dp_bit;
  logic                 blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign tick        = &prescaler;
  assign blink_phase = blink_cnt[BLINK_DIV-1];

  // upper_zero[k]: snapshot nibbles k..DIGITS-1 are all zero
  for (genvar k = 0; k < DIGITS; k++) begin : g_uz
    assign upper_zero[k] = ~|snap_data[4*DIGITS-1:4*k];
  end

  // Active-sense decode of the currently selected digit
  always_comb begin
    anode_c = '0;
    nib     = 4'd0;
    dp_bit  = 1'b0;
    blank   = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (digit_idx == IW'(k)) begin
        anode_c[k] = 1'b1;
        nib        = snap_data[4*k +: 4];
        dp_bit     = snap_dp[k];
        blank      = (blank_lz && (k != 0) && upper_zero[k]) ||
                     (blink_mask[k] && blink_phase);
      end
    end
    seg_c = blank ? 8'h00 : {dp_bit, hex7(nib)};
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      prescaler <= '0;
      blink_cnt <= '0;
      digit_idx <= '0;
      snap_data <= '0;
      snap_dp   <= '0;
      anode     <= AN_OFF;
      segment   <= SEG_OFF;
    end else begin
      prescaler <= prescaler + SCAN_DIV'(1);
      blink_cnt <= blink_cnt + BLINK_DIV'(1);
      if (tick) begin
        digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + IW'(1);
      end
      if (load) begin
        snap_data <= data;
        snap_dp   <= dp;
      end
      anode   <= anode_c ^ AN_OFF;
      segment <= seg_c ^ SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: the driver pushes model predictions, a monitor pops
// and compares the registered pins one step after each rising edge.
module tb_seg_scan_ctrl;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 2;
  localparam int BLINK_DIV    = 4;
  localparam int SCAN_PERIOD  = 1 << SCAN_DIV;
  localparam int BLINK_PERIOD = 1 << BLINK_DIV;

  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        iclk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic        load = 1'b0;
  logic [3:0]  dp = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  anode;
  logic [7:0]  segment;
  logic [1:0]  digit_idx;

  seg_scan_ctrl #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .ACTIVE_LOW(1)
  ) dut (
    .iclk(iclk), .rst(rst), .data(data), .load(load), .dp(dp),
    .blank_lz(blank_lz), .blink_mask(blink_mask),
    .anode(anode), .segment(segment), .digit_idx(digit_idx)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic [3:0] anode;
    logic [7:0] segment;
    logic [1:0] idx;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: edges since last reset plus the captured digits
  int         m_cnt = 0;
  logic [3:0] m_nib [DIGITS];
  logic [3:0] m_dp = '0;

  function automatic logic all_zero_from(input int k);
    for (int j = k; j < DIGITS; j++) if (m_nib[j] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cycle(input logic r, input logic ld, input logic [15:0] d, input logic [3:0] p,
                       input logic bl, input logic [3:0] bm, input string tag);
    exp_t e;
    int   k;
    logic ph;
    logic blk;
    logic [7:0] act;
    @(negedge iclk);
    rst = r; load = ld; data = d; dp = p; blank_lz = bl; blink_mask = bm;
    if (r) begin
      e.anode = 4'hF; e.segment = 8'hFF; e.idx = 2'd0;
      m_cnt = 0; m_dp = '0;
      for (int j = 0; j < DIGITS; j++) m_nib[j] = 4'd0;
    end else begin
      k   = (m_cnt / SCAN_PERIOD) % DIGITS;
      ph  = (m_cnt % BLINK_PERIOD) >= (BLINK_PERIOD / 2);
      blk = (bl && k != 0 && all_zero_from(k)) || (bm[k] && ph);
      act = blk ? 8'h00 : {m_dp[k], HEX[m_nib[k]]};
      e.anode   = ~(4'(1) << k);
      e.segment = ~act;
      m_cnt++;
      if (ld) begin
        for (int j = 0; j < DIGITS; j++) m_nib[j] = d[4*j +: 4];
        m_dp = p;
      end
      e.idx = 2'((m_cnt / SCAN_PERIOD) % DIGITS);
    end
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic bl, input logic [3:0] bm, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, data, dp, bl, bm, tag);
  endtask

  exp_t mon_e;
  always @(posedge iclk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      if (anode !== mon_e.anode || segment !== mon_e.segment || digit_idx !== mon_e.idx) begin
        n_err++;
        $display("FAIL %s t=%0t: anode=%h segment=%h digit_idx=%0d, expected anode=%h segment=%h digit_idx=%0d",
                 mon_e.tag, $time, anode, segment, digit_idx, mon_e.anode, mon_e.segment, mon_e.idx);
      end
    end
  end

  initial begin
    logic [15:0] rd;
    logic [15:0] msk;
    logic        rbl;
    logic [3:0]  rbm;

    // Reset, then first digit
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 4'h0, "reset");
    idle(2, 1'b0, 4'h0, "first_digit");

    // Scan cadence with one dp lit
    cycle(1'b0, 1'b1, 16'h12AF, 4'b0100, 1'b0, 4'h0, "scan_load");
    idle(24, 1'b0, 4'h0, "scan");

    // Snapshot isolation
    cycle(1'b0, 1'b1, 16'h1234, 4'h0, 1'b0, 4'h0, "iso_load");
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 16'hFFFF, 4'h0, 1'b0, 4'h0, "isolation");
    cycle(1'b0, 1'b1, 16'hFFFF, 4'h0, 1'b0, 4'h0, "iso_pulse");
    idle(6, 1'b0, 4'h0, "iso_after");

    // Leading-zero blanking
    cycle(1'b0, 1'b1, 16'h0050, 4'hF, 1'b1, 4'h0, "lz_load");
    idle(20, 1'b1, 4'h0, "lz_0050");
    cycle(1'b0, 1'b1, 16'h0000, 4'h0, 1'b1, 4'h0, "lz_load0");
    idle(20, 1'b1, 4'h0, "lz_0000");

    // Blink on digit 0 only
    cycle(1'b0, 1'b1, 16'h8888, 4'h0, 1'b0, 4'b0001, "blink_load");
    idle(40, 1'b0, 4'b0001, "blink");

    // Reset while digit 2 is being scanned
    while (((m_cnt / SCAN_PERIOD) % DIGITS) != 2) idle(1, 1'b0, 4'h0, "to_idx2");
    cycle(1'b1, 1'b0, data, dp, 1'b0, 4'h0, "midscan_rst");
    idle(6, 1'b0, 4'h0, "after_rst");

    // Load coincident with the digit advance
    cycle(1'b0, 1'b1, 16'h4321, 4'h0, 1'b0, 4'h0, "pre_collide");
    while ((m_cnt % SCAN_PERIOD) != SCAN_PERIOD - 1) idle(1, 1'b0, 4'h0, "to_tick");
    cycle(1'b0, 1'b1, 16'hDCBE, 4'b0010, 1'b0, 4'h0, "collide_load");
    idle(8, 1'b0, 4'h0, "collide");

    // Randomised traffic
    rbl = 1'b0;
    rbm = 4'h0;
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 4))
        0: msk = 16'hFFFF;
        1: msk = 16'h00FF;
        2: msk = 16'h000F;
        3: msk = 16'h0F0F;
        default: msk = 16'h0000;
      endcase
      rd = 16'($urandom) & msk;
      if ((i % 50) == 0) begin
        rbl = 1'($urandom);
        rbm = 4'($urandom);
      end
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), rd, 4'($urandom),
            rbl, rbm, "random");
    end

    @(negedge iclk);
    @(negedge iclk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised multiplexed seven-segment display driver for board-level debug tops.
- Scans DIGITS common-anode digits from a snapshot register, with:
  - per-digit decimal points
  - leading-zero blanking
  - per-digit blink
  - configurable refresh rate and polarity
- Sits between CPU/debug probe buses and the board anode/segment pins, and replaces ad-hoc count-driven scan logic in tops.

Parameters:
- DIGITS, 4, number of digits scanned (>=1).
- SCAN_DIV, 16, prescaler width; the digit advances every 2^SCAN_DIV iclk cycles (>=1).
- BLINK_DIV, 26, blink counter width; blink phase = MSB of the blink counter (>=1).
- ACTIVE_LOW, 1, 1 = anode and segment outputs active-low; 0 = active-high.

Ports:
- iclk, input, 1, system clock.
- rst, input, 1, reset.
- data, input, 4*DIGITS, hex nibbles; digit k = data[4k+3:4k], digit 0 rightmost.
- load, input, 1, capture data/dp into the snapshot on this edge.
- dp, input, DIGITS, decimal point enable per digit (1 = lit).
- blank_lz, input, 1, enable leading-zero blanking.
- blink_mask, input, DIGITS, 1 = digit blinks.
- anode, output, DIGITS, digit enables (one-hot in active sense).
- segment, output, 8, [7]=dp, [6]=g … [0]=a.
- digit_idx, output, max(1,clog2(DIGITS)), index of the digit currently driven.

Interface decision: one clock (iclk); reset rst is synchronous and active-high.

Behaviour:
- Reset (rst=1 at a rising iclk edge):
  - prescaler=0, blink counter=0, digit_idx=0, snapshot data=0, snapshot dp=0.
  - anode all inactive; segment all inactive (ACTIVE_LOW=1: anode all 1s, segment=8'hFF).
- rst has priority over load and over all counters, including mid-scan.
- Prescaler: SCAN_DIV-bit free-running up-counter, wraps. tick=1 in the cycle the prescaler equals all-ones.
- digit_idx:
  - On tick, increments; wraps DIGITS-1 -> 0.
  - For non-power-of-2 DIGITS it never reaches DIGITS.
  - DIGITS=1: digit_idx constantly 0.
- Blink counter: BLINK_DIV-bit free-running, wraps. blink_phase = MSB.
- Snapshot:
  - On load=1, snap_data<=data and snap_dp<=dp.
  - Otherwise holds.
  - Live data changes without load never reach the outputs.
- Leading-zero blanking:
  - Digit k is blank if blank_lz=1, k!=0, and snap nibbles k..DIGITS-1 are all zero.
  - Digit 0 is never LZ-blanked.
  - Blanking ignores dp: a blanked digit shows no dp either.
- Blink: digit k is blank if blink_mask[k]=1 and blink_phase=1.
- Output pipeline:
  - anode and segment are registered.
  - Each cycle they are computed from the current digit_idx, snapshot, blank_lz, blink_mask and blink_phase.
  - Latency is 1 cycle from any change of those terms to the pins.
  - The first post-reset cycle drives digit 0.
- Active-sense encoding (before polarity inversion):
  - anode = 1<<digit_idx.
  - segment[6:0] = hex decode; segment[7] = snap_dp[idx].
  - Blank digit: anode still selected, segment = all inactive.
- Hex decode, active-sense {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- ACTIVE_LOW=1: anode and segment are bitwise inverted on output. Digit 0 value 0 -> segment 8'hC0.
- Simultaneous load and tick:
  - The snapshot updates and the index advances on the same edge.
  - The next registered output uses the new snapshot at the new index.
- Anti-ghosting: exactly one anode is active per cycle after the first post-reset cycle. No cycle has two active anodes.

Test Plan (DIGITS=4, SCAN_DIV=2, BLINK_DIV=4, ACTIVE_LOW=1 unless noted):
1. Reset and first digit:
   - Hold rst 3 cycles -> anode=4'hF, segment=8'hFF, digit_idx=0.
   - Release; one cycle later -> anode=4'hE, segment=8'hC0.
2. Scan cadence:
   - load data=16'h12AF, dp=4'b0100.
   - digit_idx steps 0,1,2,3,0 every 4 cycles.
   - segments (one cycle after each step) are 8E, 88, 24 (dp lit), F9; anode cycles E, D, B, 7.
3. Snapshot isolation:
   - After loading 16'h1234, drive data=16'hFFFF without load for 40 cycles -> segments still decode 4,3,2,1.
   - Pulse load -> F appears on the next driven digit.
4. Leading-zero blanking:
   - load 16'h0050, blank_lz=1 -> digits 3 and 2 give segment=8'hFF with anode active; digit 1 = 8'h92; digit 0 = 8'hC0.
   - load 16'h0000 -> only digit 0 is lit (8'hC0).
5. Blink:
   - blink_mask=4'b0001 -> digit 0 is blank (8'hFF) in cycles where blink counter MSB=1, lit otherwise.
   - Other digits are unaffected.
6. Mid-scan reset and load/tick collision:
   - Assert rst while digit_idx=2 -> next cycle anode=4'hF, digit_idx=0, snapshot=0.
   - Separately, assert load coincident with tick -> the next output shows the new nibble at the advanced index.
